// File: rtl/gold_nic.sv
// gold_nic: network-interface controller between a core and its router's PE port.
// Builds 64-bit mesh packets from core requests, queues them in an injection FIFO,
// injects them under an IDLE/SEND/GAP handshake with the router, and buffers
// ejected packets (2 entries) for the core.
// Optional feature: define GOLD_NIC_STATS_EN to build the inj_cnt/ej_cnt counters;
// without it both outputs are tied to zero.
module gold_nic #(
    parameter int PACKET_SIZE = 64,
    parameter int NODE_X      = 0,
    parameter int NODE_Y      = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_dst_x,
    input  logic [3:0]             req_dst_y,
    input  logic [31:0]            req_data,
    output logic                   pesi,
    input  logic                   peri,
    output logic [PACKET_SIZE-1:0] pedi,
    input  logic                   peso,
    output logic                   pero,
    input  logic [PACKET_SIZE-1:0] pedo,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_src_x,
    output logic [3:0]             rsp_src_y,
    output logic [31:0]            rsp_data,
    output logic                   err_self,
    output logic [15:0]            inj_cnt,
    output logic [15:0]            ej_cnt
);

    localparam int         AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] NX   = 4'(NODE_X);
    localparam logic [3:0] NY   = 4'(NODE_Y);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } inj_state_t;

    inj_state_t state_q, state_d;

    logic          x_dir, y_dir;
    logic [3:0]    x_hops, y_hops;
    logic [62:0]   req_pkt;
    logic          self_addr;
    logic          accept;
    logic          push;
    logic          pop;

    logic [62:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic [62:0]   pkt_q;

    logic [39:0]   ej_mem [2];
    logic          ej_wr, ej_rd;
    logic [1:0]    ej_count;
    logic          cap;
    logic          rsp_pop;
    logic [39:0]   ej_head;
    logic          unused_pedo_bits;

    // Packet header fields are derived from the request destination relative to this node.
    always_comb begin
        x_dir     = (req_dst_x < NX);
        y_dir     = (req_dst_y < NY);
        x_hops    = x_dir ? (NX - req_dst_x) : (req_dst_x - NX);
        y_hops    = y_dir ? (NY - req_dst_y) : (req_dst_y - NY);
        req_pkt   = {x_dir, y_dir, 5'd0, x_hops, y_hops, NX, NY, 8'd0, req_data};
        self_addr = (req_dst_x == NX) && (req_dst_y == NY);
    end

    assign req_ready = !reset && (fifo_count != FULL);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !self_addr;

    // FIFO payload storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_pkt;
        end
    end

    // FIFO pointers and occupancy; push and pop may land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Injection state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Injection next-state: pop the head only from IDLE when the router is ready.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((fifo_count != '0) && peri) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holds the packet being injected during its SEND cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q <= '0;
        end else if (pop) begin
            pkt_q <= mem[rd_ptr];
        end
    end

    assign pesi = (state_q == SEND);
    assign pedi = pesi ? {polarity, pkt_q} : '0;

    // Sticky flag for dropped self-addressed requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_self <= 1'b0;
        end else if (accept && self_addr) begin
            err_self <= 1'b1;
        end
    end

    assign pero    = !reset && (ej_count != 2'd2);
    assign cap     = peso && pero;
    assign rsp_valid = (ej_count != 2'd0);
    assign rsp_pop = rsp_valid && rsp_ready;
    assign ej_head = ej_mem[ej_rd];

    assign rsp_src_x = rsp_valid ? ej_head[39:36] : 4'd0;
    assign rsp_src_y = rsp_valid ? ej_head[35:32] : 4'd0;
    assign rsp_data  = rsp_valid ? ej_head[31:0]  : 32'd0;

    assign unused_pedo_bits = ^{pedo[63:48], pedo[39:32]};

    // Ejection buffer storage keeps only the fields the core sees.
    always_ff @(posedge clk) begin
        if (cap) begin
            ej_mem[ej_wr] <= {pedo[47:44], pedo[43:40], pedo[31:0]};
        end
    end

    // Ejection buffer pointers and occupancy; capture and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            ej_wr    <= 1'b0;
            ej_rd    <= 1'b0;
            ej_count <= 2'd0;
        end else begin
            if (cap) begin
                ej_wr <= ~ej_wr;
            end
            if (rsp_pop) begin
                ej_rd <= ~ej_rd;
            end
            case ({cap, rsp_pop})
                2'b10:   ej_count <= ej_count + 2'd1;
                2'b01:   ej_count <= ej_count - 2'd1;
                default: ej_count <= ej_count;
            endcase
        end
    end

`ifdef GOLD_NIC_STATS_EN
    logic [15:0] inj_q, ej_q;

    // Statistics: one count per SEND cycle and per ejection capture, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            inj_q <= '0;
            ej_q  <= '0;
        end else begin
            if (pesi) begin
                inj_q <= inj_q + 16'd1;
            end
            if (cap) begin
                ej_q <= ej_q + 16'd1;
            end
        end
    end

    assign inj_cnt = inj_q;
    assign ej_cnt  = ej_q;
`else
    assign inj_cnt = 16'd0;
    assign ej_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_gold_nic.sv
// tb_gold_nic: directed bench for gold_nic at node (1,1) with a queue-based
// reference model checked every cycle plus hand-computed literal expectations.
module tb_gold_nic;

    localparam int NX    = 1;
    localparam int NY    = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dst_x = '0;
    logic [3:0]  req_dst_y = '0;
    logic [31:0] req_data = '0;
    logic        pesi;
    logic        peri = 1'b0;
    logic [63:0] pedi;
    logic        peso = 1'b0;
    logic        pero;
    logic [63:0] pedo = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_src_x, rsp_src_y;
    logic [31:0] rsp_data;
    logic        err_self;
    logic [15:0] inj_cnt, ej_cnt;

    gold_nic #(
        .PACKET_SIZE(64),
        .NODE_X     (NX),
        .NODE_Y     (NY),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dst_x (req_dst_x),
        .req_dst_y (req_dst_y),
        .req_data  (req_data),
        .pesi      (pesi),
        .peri      (peri),
        .pedi      (pedi),
        .peso      (peso),
        .pero      (pero),
        .pedo      (pedo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_src_x (rsp_src_x),
        .rsp_src_y (rsp_src_y),
        .rsp_data  (rsp_data),
        .err_self  (err_self),
        .inj_cnt   (inj_cnt),
        .ej_cnt    (ej_cnt)
    );

    // Free-running clock and mesh polarity that flips every cycle.
    always #5 clk = ~clk;
    always @(posedge clk) polarity <= ~polarity;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: pending packets, ejection contents, last strobe cycle.
    logic [62:0] mq[$];
    logic [39:0] eq[$];
    logic [62:0] m_send_pkt = '0;
    int          m_last_pulse = -100;
    int          cyc = 0;
    bit          m_err = 0;
    int          m_inj = 0;
    int          m_ej = 0;
    bit          started = 0;

    function automatic logic [62:0] mkPkt(input int dx, input int dy, input logic [31:0] d);
        logic xd;
        logic yd;
        int   hx;
        int   hy;
        xd = (dx < NX);
        yd = (dy < NY);
        hx = (dx >= NX) ? dx - NX : NX - dx;
        hy = (dy >= NY) ? dy - NY : NY - dy;
        return {xd, yd, 5'd0, 4'(hx), 4'(hy), 4'(NX), 4'(NY), 8'd0, d};
    endfunction

    function automatic logic [63:0] mkEj(input logic [3:0] sx, input logic [3:0] sy, input logic [31:0] d);
        return {8'hA5, 8'h3C, sx, sy, 8'h5A, d};
    endfunction

    // Model: a packet may be launched when queued, peri was high, and no strobe
    // occurred in the two preceding cycles; launches show up one cycle later.
    always @(posedge clk) begin : model_blk
        int prev;
        bit rr;
        bit decide;
        bit mcap;
        bit mpop;
        cyc++;
        prev = cyc - 1;
        if (reset) begin
            mq.delete();
            eq.delete();
            m_last_pulse = -100;
            m_err = 0;
            m_inj = 0;
            m_ej = 0;
            started = 1;
        end else begin
            rr     = (mq.size() < DEPTH);
            decide = (mq.size() > 0) && peri && (prev - m_last_pulse >= 2);
            if (m_last_pulse == prev) m_inj++;
            mcap = peso && (eq.size() < 2);
            mpop = (eq.size() > 0) && rsp_ready;
            if (decide) begin
                m_send_pkt = mq.pop_front();
                m_last_pulse = cyc;
            end
            if (req_valid && rr) begin
                if (req_dst_x == NX && req_dst_y == NY) m_err = 1;
                else mq.push_back(mkPkt(int'(req_dst_x), int'(req_dst_y), req_data));
            end
            if (mpop) void'(eq.pop_front());
            if (mcap) begin
                eq.push_back({pedo[47:44], pedo[43:40], pedo[31:0]});
                m_ej++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, mid-cycle.
    always @(negedge clk) begin : cmp_blk
        bit          ep;
        logic [63:0] exp_rsp;
        if (started) begin
            ep = (m_last_pulse == cyc);
            checkOutput("pesi", pesi, ep);
            checkOutput("pedi", pedi, ep ? {polarity, m_send_pkt} : 64'd0);
            checkOutput("req_ready", req_ready, !reset && (mq.size() < DEPTH));
            checkOutput("pero", pero, !reset && (eq.size() < 2));
            checkOutput("rsp_valid", rsp_valid, eq.size() > 0);
            exp_rsp = 64'd0;
            if (eq.size() > 0) exp_rsp = {24'd0, eq[0]};
            checkOutput("rsp_fields", {24'd0, rsp_src_x, rsp_src_y, rsp_data}, exp_rsp);
            checkOutput("err_self", err_self, m_err);
`ifdef GOLD_NIC_STATS_EN
            checkOutput("inj_cnt", inj_cnt, 16'(m_inj));
            checkOutput("ej_cnt", ej_cnt, 16'(m_ej));
`else
            checkOutput("inj_cnt", inj_cnt, 16'd0);
            checkOutput("ej_cnt", ej_cnt, 16'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] x, input logic [3:0] y, input logic [31:0] d);
        req_valid = v;
        req_dst_x = x;
        req_dst_y = y;
        req_data  = d;
    endtask

    task automatic waitPulse(input int budget, output logic [63:0] pkt, output int waited);
        bit seen;
        seen = 0;
        waited = 0;
        pkt = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            waited = i + 1;
            if (pesi === 1'b1) begin
                seen = 1;
                pkt = pedi;
            end
        end
        if (!seen) checkOutput("pulse_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] seen_pay [8];
    int          seen_n;

    task automatic collectPulses(input int cycles);
        seen_n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (pesi === 1'b1) begin
                if (seen_n < 8) seen_pay[seen_n] = pedi[31:0];
                seen_n++;
            end
        end
    endtask

    // Directed scenarios with literal expectations.
    initial begin : stim
        logic [63:0] pkt;
        int          waited;
        int          exp_inj;
        int          exp_ej;

        // Reset values.
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rst_pesi", pesi, 0);
        checkOutput("rst_pedi", pedi, 0);
        checkOutput("rst_pero", pero, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("first_pero", pero, 1);
        checkOutput("first_req_ready", req_ready, 1);

        // Single request to (0,2): x toward smaller, y toward larger, one hop each.
        tick();
        peri = 1'b1;
        applyStimulus(1'b1, 4'd0, 4'd2, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 32'd0);
        waitPulse(10, pkt, waited);
        checkOutput("single_pkt", {1'b0, pkt[62:0]}, 64'h40111100DEADBEEF);
        checkOutput("vc_polarity", pkt[63], polarity);
        checkOutput("accept_to_pesi", waited, 2);
        collectPulses(6);
        checkOutput("single_pulse_only", seen_n, 0);

        // Fill the FIFO with the router stalled; the fifth request is refused.
        tick();
        peri = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd3, 4'd0, 32'h100 + i);
            @(negedge clk);
            if (i == 3) checkOutput("ready_before_4th", req_ready, 1);
            if (i == 4) checkOutput("ready_full", req_ready, 0);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 32'd0);
        peri = 1'b1;
        collectPulses(14);
        checkOutput("burst_count", seen_n, 4);
        for (int k = 0; k < 4; k++) checkOutput("burst_order", seen_pay[k], 32'h100 + k);

        // Self-addressed request is dropped and flagged.
        applyStimulus(1'b1, 4'd1, 4'd1, 32'h55);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 32'd0);
        collectPulses(6);
        checkOutput("self_no_pulse", seen_n, 0);
        checkOutput("self_err", err_self, 1);

        // Ejection buffer fills at two entries, then drains in order.
        tick();
        rsp_ready = 1'b0;
        peso = 1'b1;
        pedo = mkEj(4'd2, 4'd3, 32'hAAAA0001);
        tick();
        pedo = mkEj(4'd4, 4'd5, 32'hAAAA0002);
        tick();
        pedo = mkEj(4'd6, 4'd7, 32'hAAAA0003);
        @(negedge clk);
        checkOutput("ej_pero_full", pero, 0);
        tick();
        peso = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("ej_first_data", rsp_data, 32'hAAAA0001);
        checkOutput("ej_first_src_x", rsp_src_x, 4'd2);
        tick();
        @(negedge clk);
        checkOutput("ej_second_data", rsp_data, 32'hAAAA0002);
        checkOutput("ej_second_src_y", rsp_src_y, 4'd5);
        tick();
        @(negedge clk);
        checkOutput("ej_drained", rsp_valid, 0);
        checkOutput("ej_pero_back", pero, 1);

        // Reset while packets are queued and one is on the wire.
        tick();
        peri = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd2, 4'd2, 32'h200 + i);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 32'd0);
        peri = 1'b1;
        waitPulse(6, pkt, waited);
        #1 reset = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("pesi_after_reset", pesi, 0);
        checkOutput("req_ready_in_reset", req_ready, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("req_ready_after_reset", req_ready, 1);
        checkOutput("err_cleared", err_self, 0);
        collectPulses(10);
        checkOutput("no_inj_after_reset", seen_n, 0);

        // Three injections and two ejections for the statistics counters.
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(1'b1, 4'd0, 4'd0, 32'h300 + i);
            tick();
            applyStimulus(1'b0, 4'd0, 4'd0, 32'd0);
            waitPulse(6, pkt, waited);
            checkOutput("stats_pkt_payload", pkt[31:0], 32'h300 + i);
        end
        tick();
        rsp_ready = 1'b1;
        peso = 1'b1;
        pedo = mkEj(4'd8, 4'd9, 32'hBBBB0001);
        tick();
        pedo = mkEj(4'd10, 4'd11, 32'hBBBB0002);
        tick();
        peso = 1'b0;
        repeat (3) tick();
        @(negedge clk);
`ifdef GOLD_NIC_STATS_EN
        exp_inj = 3;
        exp_ej  = 2;
`else
        exp_inj = 0;
        exp_ej  = 0;
`endif
        checkOutput("stats_inj", inj_cnt, 16'(exp_inj));
        checkOutput("stats_ej", ej_cnt, 16'(exp_ej));

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
